// File: rtl/qix_audio_pkg.sv
// Shared types, fixed-point constants and output saturation for the Qix audio filter.
package qix_audio_pkg;

  typedef enum logic [2:0] {IDLE, LP_L, LP_R, HP_L, HP_R, OUT} state_t;

  localparam int ACC_W = 24;
  localparam int FRAC  = 8;

  localparam logic signed [ACC_W:0] S16_MAX = 25'sd32767;
  localparam logic signed [ACC_W:0] S16_MIN = -25'sd32768;

  // Clamp a widened difference into the 16-bit sample range instead of wrapping.
  function automatic logic signed [15:0] sat16(input logic signed [ACC_W:0] v);
    if (v > S16_MAX) return 16'sh7fff;
    if (v < S16_MIN) return 16'sh8000;
    return 16'(v);
  endfunction

endpackage

// File: rtl/qix_audio_filter_step.sv
// Shared one-pole update y = a + ((b - a) >>> s), difference taken one bit wider to avoid overflow.
module qix_shift_step
  import qix_audio_pkg::*;
(
  input  logic signed [ACC_W-1:0] a_i,
  input  logic signed [ACC_W-1:0] b_i,
  input  logic        [3:0]       s_i,
  output logic signed [ACC_W-1:0] y_o
);

  logic signed [ACC_W:0] diff;
  logic signed [ACC_W:0] step;

  assign diff = $signed({b_i[ACC_W-1], b_i}) - $signed({a_i[ACC_W-1], a_i});
  assign step = diff >>> s_i;
  // The result always lies between a and b, so truncating back to ACC_W bits is exact.
  assign y_o  = ACC_W'($signed({a_i[ACC_W-1], a_i}) + step);

endmodule

// File: rtl/qix_audio_filter.sv
// Stereo sample-rate decimator with one-pole RC low-pass and DC-blocking high-pass, one shared datapath.
module qix_audio_filter
  import qix_audio_pkg::*;
#(
  parameter int CLK_DIV  = 416,
  parameter int LP_SHIFT = 2,
  parameter int HP_SHIFT = 8
) (
  input  logic               clk_20m,
  input  logic               reset,
  input  logic signed [15:0] in_l,
  input  logic signed [15:0] in_r,
  input  logic               mute,
  output logic signed [15:0] out_l,
  output logic signed [15:0] out_r,
  output logic               out_valid
);

  localparam int               CNT_W    = 12;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [3:0]       LP_S     = 4'(LP_SHIFT);
  localparam logic [3:0]       HP_S     = 4'(HP_SHIFT);

  state_t                  state_q;
  logic [CNT_W-1:0]        cnt_q;
  logic signed [ACC_W-1:0] x_l_q, x_r_q;
  logic signed [ACC_W-1:0] lp_l_q, lp_r_q, hp_l_q, hp_r_q;
  logic signed [15:0]      out_l_q, out_r_q;
  logic                    valid_q;

  logic                    tick;
  logic signed [ACC_W-1:0] step_a, step_b, step_y;
  logic [3:0]              step_s;
  logic signed [ACC_W:0]   band_l, band_r;

  assign tick = (cnt_q == CNT_LAST);

  // Low-pass minus high-pass state is the DC-blocked signal; drop the fraction bits.
  assign band_l = ($signed({lp_l_q[ACC_W-1], lp_l_q}) - $signed({hp_l_q[ACC_W-1], hp_l_q})) >>> FRAC;
  assign band_r = ($signed({lp_r_q[ACC_W-1], lp_r_q}) - $signed({hp_r_q[ACC_W-1], hp_r_q})) >>> FRAC;

  always_comb begin
    step_a = lp_l_q;
    step_b = x_l_q;
    step_s = LP_S;
    case (state_q)
      LP_R: begin
        step_a = lp_r_q;
        step_b = x_r_q;
      end
      HP_L: begin
        step_a = hp_l_q;
        step_b = lp_l_q;
        step_s = HP_S;
      end
      HP_R: begin
        step_a = hp_r_q;
        step_b = lp_r_q;
        step_s = HP_S;
      end
      default: ;
    endcase
  end

  qix_shift_step u_step (
    .a_i (step_a),
    .b_i (step_b),
    .s_i (step_s),
    .y_o (step_y)
  );

  always_ff @(posedge clk_20m or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      x_l_q   <= '0;
      x_r_q   <= '0;
      lp_l_q  <= '0;
      lp_r_q  <= '0;
      hp_l_q  <= '0;
      hp_r_q  <= '0;
      out_l_q <= '0;
      out_r_q <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      cnt_q   <= tick ? '0 : cnt_q + CNT_W'(1);
      case (state_q)
        IDLE: begin
          // Ticks seen in any other state are dropped; the sequence is far shorter than a sample period.
          if (tick) begin
            x_l_q   <= mute ? '0 : {in_l, {FRAC{1'b0}}};
            x_r_q   <= mute ? '0 : {in_r, {FRAC{1'b0}}};
            state_q <= LP_L;
          end
        end
        LP_L: begin
          lp_l_q  <= step_y;
          state_q <= LP_R;
        end
        LP_R: begin
          lp_r_q  <= step_y;
          state_q <= HP_L;
        end
        HP_L: begin
          hp_l_q  <= step_y;
          state_q <= HP_R;
        end
        HP_R: begin
          hp_r_q  <= step_y;
          state_q <= OUT;
        end
        OUT: begin
          out_l_q <= sat16(band_l);
          out_r_q <= sat16(band_r);
          valid_q <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign out_l     = out_l_q;
  assign out_r     = out_r_q;
  assign out_valid = valid_q;

endmodule

// File: tb/tb_qix_audio_filter.sv
// Directed bench: step-response table, latency/period, saturation, mute decay, mid-sequence reset.
module tb_qix_audio_filter;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #25 clk = ~clk;

  logic signed [15:0] a_in_l = '0, a_in_r = '0, a_out_l, a_out_r;
  logic signed [15:0] b_in_l = '0, b_in_r = '0, b_out_l, b_out_r;
  logic signed [15:0] c_in_l = '0, c_in_r = '0, c_out_l, c_out_r;
  logic a_mute = 1'b0, b_mute = 1'b0, c_mute = 1'b0;
  logic a_valid, b_valid, c_valid;

  qix_audio_filter #(.CLK_DIV(416), .LP_SHIFT(2), .HP_SHIFT(8)) dut_a (
    .clk_20m(clk), .reset(rst), .in_l(a_in_l), .in_r(a_in_r), .mute(a_mute),
    .out_l(a_out_l), .out_r(a_out_r), .out_valid(a_valid));

  qix_audio_filter #(.CLK_DIV(8), .LP_SHIFT(2), .HP_SHIFT(8)) dut_b (
    .clk_20m(clk), .reset(rst), .in_l(b_in_l), .in_r(b_in_r), .mute(b_mute),
    .out_l(b_out_l), .out_r(b_out_r), .out_valid(b_valid));

  qix_audio_filter #(.CLK_DIV(8), .LP_SHIFT(2), .HP_SHIFT(15)) dut_c (
    .clk_20m(clk), .reset(rst), .in_l(c_in_l), .in_r(c_in_r), .mute(c_mute),
    .out_l(c_out_l), .out_r(c_out_r), .out_valid(c_valid));

  typedef struct {
    logic signed [15:0] in_l;
    logic signed [15:0] in_r;
    logic               mute;
    int                 exp_l;
    int                 exp_r;
  } vec_t;

  vec_t tbl[8];
  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic chk_rng(input string name, input int act, input int lo, input int hi);
    n_total++;
    if (act >= lo && act <= hi) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
  endtask

  function automatic bit vsel(input int k);
    case (k)
      0:       return a_valid;
      1:       return b_valid;
      default: return c_valid;
    endcase
  endfunction

  // Counts rising edges until the chosen instance pulses out_valid.
  task automatic wait_valid(input int k, input int limit, output int n);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!vsel(k) && n < limit);
    if (!vsel(k)) begin
      n_total++;
      $display("FAIL timeout: dut %0d gave no out_valid within %0d cycles", k, limit);
      n = -1;
    end
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, bad, prev, nonmono, jumps, maxv, held_l;

    tbl[0] = '{16'sd16384,  16'sd0,    1'b0, 4080,  0};
    tbl[1] = '{16'sd16384,  16'sd0,    1'b0, 7124,  0};
    tbl[2] = '{16'sd16384,  16'sd0,    1'b0, 9391,  0};
    tbl[3] = '{16'sd16384,  16'sd0,    1'b0, 11075, 0};
    tbl[4] = '{16'sd16384,  16'sd0,    1'b0, 12323, 0};
    tbl[5] = '{16'sd16384, -16'sd1024, 1'b1, 9163,  0};
    tbl[6] = '{16'sd0,     -16'sd1024, 1'b0, 6793, -255};
    tbl[7] = '{16'sd0,     -16'sd1024, 1'b0, 5016, -446};

    // Reset hold and step-response table on the 416-cycle instance.
    #1 rst = 1'b1;
    a_in_l = tbl[0].in_l; a_in_r = tbl[0].in_r; a_mute = tbl[0].mute;
    bad = 0;
    repeat (4) begin
      @(negedge clk);
      if (a_out_l != 0 || a_out_r != 0 || a_valid) bad++;
    end
    chk("reset_hold", bad, 0);
    release_reset();
    for (int i = 0; i < 8; i++) begin
      a_in_l = tbl[i].in_l; a_in_r = tbl[i].in_r; a_mute = tbl[i].mute;
      wait_valid(0, 500, n);
      if (i == 0) chk("first_latency", n, 421);
      else if (i == 1) chk("period", n + 1, 416);
      else chk("period", n, 416);
      held_l = a_out_l;
      $display("row %0d: in_l=%0d in_r=%0d mute=%0b -> out_l=%0d out_r=%0d wait=%0d",
               i, tbl[i].in_l, tbl[i].in_r, tbl[i].mute, a_out_l, a_out_r, n);
      chk("row_out_l", a_out_l, tbl[i].exp_l);
      chk("row_out_r", a_out_r, tbl[i].exp_r);
      if (i == 0) begin
        @(posedge clk);
        #1;
        chk("valid_width", int'(a_valid), 0);
        chk("out_hold", a_out_l, held_l);
      end
    end

    // Input glitch away from the tick must not be captured.
    rst = 1'b1;
    a_in_l = '0; a_in_r = '0; a_mute = 1'b0;
    repeat (3) @(posedge clk);
    release_reset();
    repeat (200) @(posedge clk);
    #1 a_in_l = 16'sd30000;
    @(posedge clk);
    #1 a_in_l = '0;
    wait_valid(0, 500, n);
    $display("glitch: out_l=%0d wait=%0d", a_out_l, n);
    chk("glitch_out_l", a_out_l, 0);

    // Reset asserted while the left high-pass update is pending.
    rst = 1'b1;
    a_in_l = 16'sd16384;
    repeat (3) @(posedge clk);
    release_reset();
    for (int i = 0; i < 3; i++) wait_valid(0, 500, n);
    chk("midrst_pre", a_out_l, 9391);
    repeat (413) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("midrst_out_l", a_out_l, 0);
    chk("midrst_valid", int'(a_valid), 0);
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (a_valid) bad++;
    end
    chk("midrst_no_pulse", bad, 0);
    release_reset();
    wait_valid(0, 500, n);
    $display("midrst restart: out_l=%0d wait=%0d", a_out_l, n);
    chk("midrst_latency", n, 421);
    chk("midrst_first", a_out_l, 4080);

    // Saturation on the 8-cycle instance: settle at full scale, then step to negative full scale.
    rst = 1'b1;
    a_in_l = '0;
    b_in_l = 16'sd32767;
    repeat (3) @(posedge clk);
    release_reset();
    wait_valid(1, 50, n);
    chk("b_first_latency", n, 13);
    wait_valid(1, 50, n);
    chk("b_period", n, 8);
    for (int i = 0; i < 4000; i++) wait_valid(1, 20, n);
    $display("sat settled: out_l=%0d", b_out_l);
    chk_rng("sat_settled", b_out_l, 0, 2);
    b_in_l = -16'sd32768;
    wait_valid(1, 20, n);
    $display("sat step 1: out_l=%0d", b_out_l);
    chk_rng("sat_step1", b_out_l, -16323, -16317);
    wait_valid(1, 20, n);
    $display("sat step 2: out_l=%0d", b_out_l);
    chk_rng("sat_step2", b_out_l, -28500, -28490);
    wait_valid(1, 20, n);
    $display("sat step 3: out_l=%0d", b_out_l);
    chk("sat_clamp", b_out_l, -32768);
    maxv = -100000;
    for (int i = 0; i < 37; i++) begin
      wait_valid(1, 20, n);
      if (b_out_l > maxv) maxv = b_out_l;
    end
    $display("sat hold: max out_l=%0d", maxv);
    chk("sat_hold_max", maxv, -32768);
    chk("sat_out_r", b_out_r, 0);

    // Mute decay on the slow-DC-blocker instance.
    rst = 1'b1;
    b_in_l = '0;
    c_in_r = -16'sd12000;
    repeat (3) @(posedge clk);
    release_reset();
    for (int i = 0; i < 40; i++) wait_valid(2, 20, n);
    $display("mute pre: out_r=%0d", c_out_r);
    chk_rng("mute_pre", c_out_r, -12000, -11950);
    c_mute = 1'b1;
    prev = c_out_r;
    nonmono = 0;
    jumps = 0;
    for (int i = 0; i < 40; i++) begin
      wait_valid(2, 20, n);
      if (i == 0) begin
        $display("mute first: out_r=%0d", c_out_r);
        chk_rng("mute_first", c_out_r, -8995, -8975);
      end
      if (c_out_r < prev) nonmono++;
      if (c_out_r - prev > 3002) jumps++;
      prev = c_out_r;
    end
    $display("mute end: out_r=%0d nonmono=%0d jumps=%0d", c_out_r, nonmono, jumps);
    chk("mute_monotonic", nonmono, 0);
    chk("mute_jump", jumps, 0);
    chk_rng("mute_final", c_out_r, -4, 40);
    c_mute = 1'b0;
    for (int i = 0; i < 40; i++) wait_valid(2, 20, n);
    $display("unmute: out_r=%0d out_l=%0d", c_out_r, c_out_l);
    chk_rng("unmute_track", c_out_r, -12000, -11900);
    chk("unmute_out_l", c_out_l, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
